// File: rtl/pic_init_sequencer_if.sv
// CPU-side write port of the 8259 PIC, as driven by the init sequencer.
// master = sequencer (drives the bus), slave = PIC (samples it).
// Strobes are active low; rd_enable is never asserted by this master.
interface pic_init_sequencer_if;
  logic       CS;
  logic       wr_enable;
  logic       rd_enable;
  logic       A1;
  logic [7:0] data_out;

  modport master (output CS, output wr_enable, output rd_enable, output A1, output data_out);
  modport slave  (input  CS, input  wr_enable, input  rd_enable, input  A1, input  data_out);
endinterface

// File: rtl/pic_init_sequencer.sv
// pic_init_sequencer: programs an 8259 PIC with ICW1..ICW4 (plus optional OCW1) after a start pulse.
// Latency: each write is 1 + PULSE_CYC + GAP_CYC cycles; done pulses one cycle after the last GAP.
// No backpressure: start is ignored while busy; abort stops at the next safe point (never mid-strobe).
// Optional feature: define PIC_SEQ_OCW1_EN to add the ocw1 port and a trailing OCW1 mask write.
module pic_init_sequencer #(
  parameter int PULSE_CYC = 2,
  parameter int GAP_CYC   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [7:0]           icw1,
  input  logic [7:0]           icw2,
  input  logic [7:0]           icw3,
  input  logic [7:0]           icw4,
`ifdef PIC_SEQ_OCW1_EN
  input  logic [7:0]           ocw1,
`endif
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  pic_init_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [3:0] PULSE_LOAD = 4'(PULSE_CYC - 1);
  localparam logic [3:0] GAP_LOAD   = 4'(GAP_CYC - 1);

  state_t     state;
  logic [3:0] cnt;
  logic [2:0] idx;         // 0=ICW1 1=ICW2 2=ICW3 3=ICW4 4=OCW1
  logic       abort_pend;  // abort seen mid-strobe, honoured when the strobe ends

  logic [7:0] r_icw1, r_icw2, r_icw3, r_icw4, r_ocw1;

  logic       cs_q, wr_q, a1_q;
  logic [7:0] dat_q;

  logic [4:0] incl;
  logic [2:0] nxt_idx;
  logic       nxt_vld;
  logic [7:0] nxt_dat;

  assign bus.CS        = cs_q;
  assign bus.wr_enable = wr_q;
  assign bus.rd_enable = 1'b1;
  assign bus.A1        = a1_q;
  assign bus.data_out  = dat_q;

  // Which entries of the write list apply, decided by the latched ICW1.
  assign incl[0] = 1'b1;
  assign incl[1] = 1'b1;
  assign incl[2] = ~r_icw1[1];   // ICW3 only in cascade mode
  assign incl[3] = r_icw1[0];    // ICW4 only when IC4 requested
`ifdef PIC_SEQ_OCW1_EN
  assign incl[4] = 1'b1;
`else
  assign incl[4] = 1'b0;
`endif

  // Find the next listed write after the current one; skipped entries cost nothing.
  always_comb begin
    nxt_idx = idx;
    nxt_vld = 1'b0;
    for (int i = 4; i >= 1; i--) begin
      if (incl[i] && (i > int'(idx))) begin
        nxt_idx = 3'(i);
        nxt_vld = 1'b1;
      end
    end
  end

  // Byte that goes on the bus for the next write.
  always_comb begin
    case (nxt_idx)
      3'd1:    nxt_dat = r_icw2;
      3'd2:    nxt_dat = r_icw3;
      3'd3:    nxt_dat = r_icw4;
      3'd4:    nxt_dat = r_ocw1;
      default: nxt_dat = r_icw1;
    endcase
  end

  // Sequencer FSM with registered bus and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      idx        <= 3'd0;
      abort_pend <= 1'b0;
      r_icw1     <= 8'h00;
      r_icw2     <= 8'h00;
      r_icw3     <= 8'h00;
      r_icw4     <= 8'h00;
      r_ocw1     <= 8'h00;
      cs_q       <= 1'b1;
      wr_q       <= 1'b1;
      a1_q       <= 1'b0;
      dat_q      <= 8'h00;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // abort outranks start; an illegal ICW1 (bit 4 clear) is refused without touching the bus
          if (!abort && start) begin
            if (!icw1[4]) begin
              error <= 1'b1;
            end else begin
              r_icw1     <= icw1;
              r_icw2     <= icw2;
              r_icw3     <= icw3;
              r_icw4     <= icw4;
`ifdef PIC_SEQ_OCW1_EN
              r_ocw1     <= ocw1;
`endif
              error      <= 1'b0;
              idx        <= 3'd0;
              abort_pend <= 1'b0;
              cs_q       <= 1'b0;
              wr_q       <= 1'b1;
              a1_q       <= 1'b0;
              dat_q      <= icw1;
              busy       <= 1'b1;
              state      <= S_SETUP;
            end
          end
        end

        S_SETUP: begin
          if (abort) begin
            cs_q  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            wr_q  <= 1'b0;
            cnt   <= PULSE_LOAD;
            state <= S_PULSE;
          end
        end

        S_PULSE: begin
          // The strobe always runs its full length; an abort only takes effect at its end.
          if (abort) abort_pend <= 1'b1;
          if (cnt == 4'd0) begin
            wr_q <= 1'b1;
            cs_q <= 1'b1;
            if (abort || abort_pend) begin
              abort_pend <= 1'b0;
              busy       <= 1'b0;
              state      <= S_IDLE;
            end else begin
              cnt   <= GAP_LOAD;
              state <= S_GAP;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        S_GAP: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (cnt == 4'd0) begin
            if (nxt_vld) begin
              idx   <= nxt_idx;
              cs_q  <= 1'b0;
              a1_q  <= 1'b1;
              dat_q <= nxt_dat;
              state <= S_SETUP;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          cs_q  <= 1'b1;
          wr_q  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pic_init_sequencer.sv
// Bench for pic_init_sequencer: directed plan steps plus randomized ICW sets.
// Expected write lists and latencies come from the PIC init rules, not from the RTL.
module tb_pic_init_sequencer;
  localparam int P    = 2;
  localparam int G    = 2;
  localparam int WCYC = 1 + P + G;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] icw1  = 8'h00;
  logic [7:0] icw2  = 8'h00;
  logic [7:0] icw3  = 8'h00;
  logic [7:0] icw4  = 8'h00;
  logic [7:0] ocw1  = 8'h00;
  logic       busy, done, error;

  pic_init_sequencer_if bus_if();

  pic_init_sequencer #(.PULSE_CYC(P), .GAP_CYC(G)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .abort (abort),
    .icw1  (icw1),
    .icw2  (icw2),
    .icw3  (icw3),
    .icw4  (icw4),
`ifdef PIC_SEQ_OCW1_EN
    .ocw1  (ocw1),
`endif
    .busy  (busy),
    .done  (done),
    .error (error),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Bus monitor: records each completed write (latched on the rising strobe) and its strobe width.
  logic [8:0] wr_q[$];
  int         width_q[$];
  int         done_q[$];
  int         cs_falls  = 0;
  int         bad_cs    = 0;
  int         done_busy = 0;
  int         low_cnt   = 0;
  logic       wr_prev   = 1'b1;
  logic       cs_prev   = 1'b1;

  always @(negedge clk) begin
    if (bus_if.wr_enable === 1'b0) begin
      low_cnt++;
      if (bus_if.CS !== 1'b0) bad_cs++;
    end
    if (wr_prev === 1'b0 && bus_if.wr_enable === 1'b1) begin
      wr_q.push_back({bus_if.A1, bus_if.data_out});
      width_q.push_back(low_cnt);
      low_cnt = 0;
    end
    if (cs_prev === 1'b1 && bus_if.CS === 1'b0) cs_falls++;
    if (done === 1'b1) begin
      done_q.push_back(cyc);
      if (busy !== 1'b0) done_busy++;
    end
    wr_prev = bus_if.wr_enable;
    cs_prev = bus_if.CS;
  end

  // Reference write list for a given command set.
  logic [8:0] exp_q[$];
  function automatic void build_exp(input logic [7:0] b1, b2, b3, b4, b5);
    exp_q.delete();
    exp_q.push_back({1'b0, b1});
    exp_q.push_back({1'b1, b2});
    if (b1[1] == 1'b0) exp_q.push_back({1'b1, b3});
    if (b1[0] == 1'b1) exp_q.push_back({1'b1, b4});
`ifdef PIC_SEQ_OCW1_EN
    exp_q.push_back({1'b1, b5});
`else
    if (b5 === 8'hxx) exp_q.delete();  // ocw1 plays no part without the OCW1 write
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    wr_q.delete();
    width_q.delete();
    done_q.delete();
    cs_falls  = 0;
    bad_cs    = 0;
    done_busy = 0;
    low_cnt   = 0;
  endtask

  task automatic pulse_start(input logic [7:0] b1, b2, b3, b4, b5, output int sedge);
    @(posedge clk);
    #1;
    icw1 = b1; icw2 = b2; icw3 = b3; icw4 = b4; ocw1 = b5;
    start = 1'b1;
    @(posedge clk);
    #1;
    sedge = cyc;
    start = 1'b0;
  endtask

  task automatic run_full(input string tag, input logic [7:0] b1, b2, b3, b4, b5);
    int sedge;
    int n;
    clear_mon();
    build_exp(b1, b2, b3, b4, b5);
    pulse_start(b1, b2, b3, b4, b5, sedge);
    check({tag, "_err_clr"}, error, 1'b0);
    for (int i = 0; i < 400 && done_q.size() == 0; i++) @(negedge clk);
    check({tag, "_done_seen"}, done_q.size(), 1);
    if (done_q.size() > 0)
      check({tag, "_latency"}, done_q[0] - sedge + 1, exp_q.size() * WCYC + 1);
    repeat (3) @(negedge clk);
    n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
    check({tag, "_nwrites"}, wr_q.size(), exp_q.size());
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_wr%0d", tag, i), wr_q[i], exp_q[i]);
      check($sformatf("%s_width%0d", tag, i), width_q[i], P);
    end
    check({tag, "_cs_falls"}, cs_falls, exp_q.size());
    check({tag, "_strobe_in_cs"}, bad_cs, 0);
    check({tag, "_done_once"}, done_q.size(), 1);
    check({tag, "_busy_in_done"}, done_busy, 0);
  endtask

  task automatic run_bad(input string tag, input logic [7:0] b1);
    int sedge;
    clear_mon();
    pulse_start(b1, 8'h55, 8'h66, 8'h77, 8'h88, sedge);
    repeat (10) @(negedge clk);
    check({tag, "_error"}, error, 1'b1);
    check({tag, "_no_cs"}, cs_falls, 0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    int sedge;
    logic [7:0] r1;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cs", bus_if.CS, 1'b1);
    check("rst_wr", bus_if.wr_enable, 1'b1);
    check("rst_rd", bus_if.rd_enable, 1'b1);
    check("rst_a1", bus_if.A1, 1'b0);
    check("rst_data", bus_if.data_out, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single, no ICW3, with ICW4
    run_full("single", 8'h13, 8'h10, 8'hAA, 8'h01, 8'hFF);
    // Cascade with ICW3 and ICW4
    run_full("cascade", 8'h11, 8'h20, 8'h04, 8'h03, 8'hFF);

    // Illegal ICW1, then a legal start clears error
    run_bad("bad", 8'h03);
    run_full("recover", 8'h12, 8'h30, 8'h02, 8'h01, 8'hFF);

    // Abort during the first PULSE cycle of ICW2
    clear_mon();
    pulse_start(8'h13, 8'h40, 8'h00, 8'h01, 8'h00, sedge);
    for (int i = 0; i < 50 && !(bus_if.wr_enable === 1'b0 && bus_if.A1 === 1'b1); i++)
      @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_nwrites", wr_q.size(), 2);
    if (width_q.size() > 1) check("abort_width", width_q[1], P);
    check("abort_no_done", done_q.size(), 0);
    check("abort_cs", bus_if.CS, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_cs_falls", cs_falls, 2);

    // abort together with start in IDLE: nothing starts
    clear_mon();
    @(posedge clk);
    #1;
    icw1 = 8'h13; start = 1'b1; abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; abort = 1'b0;
    repeat (10) @(negedge clk);
    check("abst_no_cs", cs_falls, 0);
    check("abst_busy", busy, 1'b0);
    check("abst_no_done", done_q.size(), 0);

    // Reset during a strobe drops CS and wr_enable at once
    clear_mon();
    pulse_start(8'h11, 8'h50, 8'h08, 8'h01, 8'h00, sedge);
    for (int i = 0; i < 50 && bus_if.wr_enable !== 1'b0; i++) @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("rstmid_cs", bus_if.CS, 1'b1);
    check("rstmid_wr", bus_if.wr_enable, 1'b1);
    check("rstmid_busy", busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_full("restart", 8'h11, 8'h50, 8'h08, 8'h01, 8'h00);

`ifdef PIC_SEQ_OCW1_EN
    run_full("ocw1", 8'h13, 8'h10, 8'h00, 8'h01, 8'hFE);
`endif

    // Randomized command sets, roughly a quarter illegal
    for (int k = 0; k < 25; k++) begin
      r1 = 8'($urandom);
      r1[4] = ($urandom_range(0, 3) != 0);
      if (r1[4])
        run_full($sformatf("rnd%0d", k), r1, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      else
        run_bad($sformatf("rnd%0d", k), r1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
